stack_engine: RTL and testbench

//  Memory-stage responder for the decode-stage control FSM's stack requests (push/pop,

---
 rtl/stack_pkg.sv | 34 +++
 rtl/stack_engine.sv | 130 +++++++++++++
 tb/tb_stack_engine.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared types for the stack engine and the decode-stage control FSM that drives it.
package stack_pkg;

  typedef enum logic [1:0] {
    SRC_FLAGS = 2'b00,
    SRC_PC_HI = 2'b01,
    SRC_PC_LO = 2'b10,
    SRC_REG   = 2'b11
  } stk_src_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RESP,
    ST_FAULT
  } stk_state_t;

  localparam int          ADDR_W_DEF   = 12;
  localparam logic [11:0] SP_INIT_DEF  = 12'hFFF;
  localparam logic [11:0] SP_LIMIT_DEF = 12'h800;

  // Word written to memory for a push from the given source.
  function automatic logic [15:0] push_word(input stk_src_t src, input logic [31:0] pc,
                                            input logic [2:0] flags, input logic [15:0] rdata);
    case (src)
      SRC_FLAGS: return {13'b0, flags};
      SRC_PC_HI: return pc[31:16];
      SRC_PC_LO: return pc[15:0];
      default:   return rdata;
    endcase
  endfunction

endpackage

// File: rtl/stack_engine.sv
// Memory-stage stack responder: owns SP, performs push/pop word accesses over a
// req/ack port, reassembles a popped PC from two halves and restores flags.
module stack_engine
  import stack_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] SP_INIT  = SP_INIT_DEF,
  parameter logic [ADDR_W-1:0] SP_LIMIT = SP_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic              op_push,
  input  logic              op_pop,
  input  logic [1:0]        op_src,
  input  logic [15:0]       reg_wdata,
  input  logic [31:0]       pc_in,
  input  logic [2:0]        flags_in,
  output logic              op_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] sp,
  output logic              pop_valid,
  output logic [15:0]       pop_data,
  output logic              pc_load,
  output logic [31:0]       pc_value,
  output logic              flags_load,
  output logic [2:0]        flags_value,
  output logic              stack_fault
);

  stk_state_t  state_reg;
  stk_src_t    src_reg;
  logic [15:0] lo_shadow_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      src_reg       <= SRC_FLAGS;
      lo_shadow_reg <= '0;
      sp            <= SP_INIT;
      op_ready      <= 1'b1;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      pop_valid     <= 1'b0;
      pop_data      <= '0;
      pc_load       <= 1'b0;
      pc_value      <= '0;
      flags_load    <= 1'b0;
      flags_value   <= '0;
      stack_fault   <= 1'b0;
    end else begin
      pop_valid   <= 1'b0;
      pc_load     <= 1'b0;
      flags_load  <= 1'b0;
      stack_fault <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (op_valid && (op_push || op_pop)) begin
            op_ready <= 1'b0;
            src_reg  <= stk_src_t'(op_src);
            // Push has priority when both are requested.
            if (op_push) begin
              if (sp == SP_LIMIT) begin
                state_reg   <= ST_FAULT;
                stack_fault <= 1'b1;
              end else begin
                state_reg <= ST_WR;
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= sp;
                mem_wdata <= push_word(stk_src_t'(op_src), pc_in, flags_in, reg_wdata);
              end
            end else if (sp == SP_INIT) begin
              state_reg   <= ST_FAULT;
              stack_fault <= 1'b1;
            end else begin
              state_reg <= ST_RD;
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= sp + ADDR_W'(1);
            end
          end
        end
        ST_WR: begin
          if (mem_ack) begin
            state_reg <= ST_IDLE;
            op_ready  <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            sp        <= sp - ADDR_W'(1);
          end
        end
        ST_RD: begin
          if (mem_ack) begin
            state_reg <= ST_RESP;
            mem_req   <= 1'b0;
            sp        <= sp + ADDR_W'(1);
            pop_valid <= 1'b1;
            pop_data  <= mem_rdata;
            case (src_reg)
              SRC_PC_LO: lo_shadow_reg <= mem_rdata;
              SRC_PC_HI: begin
                pc_load  <= 1'b1;
                pc_value <= {mem_rdata, lo_shadow_reg};
              end
              SRC_FLAGS: begin
                flags_load  <= 1'b1;
                flags_value <= mem_rdata[2:0];
              end
              default: ;
            endcase
          end
        end
        default: begin
          // RESP and FAULT both last exactly one cycle.
          state_reg <= ST_IDLE;
          op_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_engine.sv
// Directed bench for stack_engine with a req/ack memory responder of programmable latency.
module tb_stack_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0, op_push = 1'b0, op_pop = 1'b0;
  logic [1:0]  op_src = 2'b00;
  logic [15:0] reg_wdata = '0;
  logic [31:0] pc_in = '0;
  logic [2:0]  flags_in = '0;
  logic        op_ready, mem_req, mem_we, mem_ack;
  logic [11:0] mem_addr, sp;
  logic [15:0] mem_wdata, mem_rdata, pop_data;
  logic        pop_valid, pc_load, flags_load, stack_fault;
  logic [31:0] pc_value;
  logic [2:0]  flags_value;

  stack_engine dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_push(op_push), .op_pop(op_pop),
    .op_src(op_src), .reg_wdata(reg_wdata), .pc_in(pc_in), .flags_in(flags_in),
    .op_ready(op_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .sp(sp),
    .pop_valid(pop_valid), .pop_data(pop_data), .pc_load(pc_load), .pc_value(pc_value),
    .flags_load(flags_load), .flags_value(flags_value), .stack_fault(stack_fault)
  );

  always #5 clk = ~clk;

  // Memory responder: ack after ack_delay cycles of mem_req.
  logic [15:0] mem [0:4095];
  int          ack_delay = 0;
  int          wait_cnt;
  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk or negedge reset) begin
    if (!reset) wait_cnt <= 0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  always @(posedge clk) begin
    if (reset && mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Results of the most recent operation.
  int          cyc, req_cycles, pv_cnt, pcl_cnt, fl_cnt, flt_cnt;
  logic        stable;
  logic [11:0] first_addr;
  logic [15:0] first_wdata, last_pd;
  logic [31:0] last_pcv;
  logic [2:0]  last_fv;

  task automatic run_op(input logic push, input logic pop, input logic [1:0] src);
    logic seen;
    op_valid = 1'b1; op_push = push; op_pop = pop; op_src = src;
    @(negedge clk);
    op_valid = 1'b0; op_push = 1'b0; op_pop = 1'b0;
    cyc = 1; req_cycles = 0; pv_cnt = 0; pcl_cnt = 0; fl_cnt = 0; flt_cnt = 0;
    stable = 1'b1; seen = 1'b0;
    while (!op_ready && cyc < 50) begin
      if (mem_req) begin
        if (!seen) begin
          first_addr = mem_addr; first_wdata = mem_wdata; seen = 1'b1;
        end else if (mem_addr !== first_addr || mem_wdata !== first_wdata) begin
          stable = 1'b0;
        end
        req_cycles++;
      end
      if (pop_valid)   begin pv_cnt++;  last_pd  = pop_data;    end
      if (pc_load)     begin pcl_cnt++; last_pcv = pc_value;    end
      if (flags_load)  begin fl_cnt++;  last_fv  = flags_value; end
      if (stack_fault) flt_cnt++;
      @(negedge clk);
      cyc++;
    end
    $display("op push=%0b pop=%0b src=%0d cycles=%0d req=%0d addr=%0h wdata=%0h sp=%0h",
             push, pop, src, cyc, req_cycles, first_addr, first_wdata, sp);
  endtask

  initial begin
    // 1: reset state
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_sp", 64'(sp), 64'hFFF);
    chk("rst_ready", 64'(op_ready), 64'd1);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_pulses", 64'({pop_valid, pc_load, flags_load, stack_fault}), 64'd0);
    chk("rst_pcvalue", 64'(pc_value), 64'd0);

    // 2: push register, zero-wait
    reg_wdata = 16'hBEEF;
    run_op(1'b1, 1'b0, 2'b11);
    chk("push_addr", 64'(first_addr), 64'hFFF);
    chk("push_data", 64'(first_wdata), 64'hBEEF);
    chk("push_cycles", 64'(cyc), 64'd2);
    chk("push_sp", 64'(sp), 64'hFFE);
    chk("push_mem", 64'(mem[12'hFFF]), 64'hBEEF);

    run_op(1'b0, 1'b1, 2'b11);
    chk("pop_reg_data", 64'(last_pd), 64'hBEEF);
    chk("pop_reg_valid", 64'(pv_cnt), 64'd1);
    chk("pop_reg_cycles", 64'(cyc), 64'd3);
    chk("pop_reg_sp", 64'(sp), 64'hFFF);

    // 3: CALL / RET
    pc_in = 32'h0001_2345;
    run_op(1'b1, 1'b0, 2'b01);
    run_op(1'b1, 1'b0, 2'b10);
    chk("call_hi_mem", 64'(mem[12'hFFF]), 64'h0001);
    chk("call_lo_mem", 64'(mem[12'hFFE]), 64'h2345);
    chk("call_sp", 64'(sp), 64'hFFD);
    pc_in = 32'h0;
    run_op(1'b0, 1'b1, 2'b10);
    chk("ret_lo_addr", 64'(first_addr), 64'hFFE);
    chk("ret_lo_noload", 64'(pcl_cnt), 64'd0);
    run_op(1'b0, 1'b1, 2'b01);
    chk("ret_hi_addr", 64'(first_addr), 64'hFFF);
    chk("ret_pcload", 64'(pcl_cnt), 64'd1);
    chk("ret_pcvalue", 64'(last_pcv), 64'h0001_2345);
    chk("ret_sp", 64'(sp), 64'hFFF);

    // 4: flags push with 3 wait states, then pop into flags
    flags_in = 3'b101;
    ack_delay = 3;
    run_op(1'b1, 1'b0, 2'b00);
    chk("flg_req_cycles", 64'(req_cycles), 64'd4);
    chk("flg_stable", 64'(stable), 64'd1);
    chk("flg_wdata", 64'(first_wdata), 64'h0005);
    chk("flg_cycles", 64'(cyc), 64'd5);
    chk("flg_sp", 64'(sp), 64'hFFE);
    ack_delay = 0;
    run_op(1'b0, 1'b1, 2'b00);
    chk("flg_load", 64'(fl_cnt), 64'd1);
    chk("flg_value", 64'(last_fv), 64'd5);
    chk("flg_no_pcload", 64'(pcl_cnt), 64'd0);

    // push and pop together: push wins
    reg_wdata = 16'h1234;
    run_op(1'b1, 1'b1, 2'b11);
    chk("both_write", 64'(mem[12'hFFF]), 64'h1234);
    chk("both_sp", 64'(sp), 64'hFFE);
    run_op(1'b0, 1'b1, 2'b11);

    // 5: underflow, then fill to the limit and overflow
    run_op(1'b0, 1'b1, 2'b11);
    chk("uflow_fault", 64'(flt_cnt), 64'd1);
    chk("uflow_noreq", 64'(req_cycles), 64'd0);
    chk("uflow_nopop", 64'(pv_cnt), 64'd0);
    chk("uflow_sp", 64'(sp), 64'hFFF);
    for (int i = 0; i < 2047; i++) begin
      reg_wdata = 16'(i);
      run_op(1'b1, 1'b0, 2'b11);
    end
    chk("fill_sp", 64'(sp), 64'h800);
    chk("fill_last", 64'(mem[12'h801]), 64'h07FE);
    reg_wdata = 16'hDEAD;
    run_op(1'b1, 1'b0, 2'b11);
    chk("oflow_fault", 64'(flt_cnt), 64'd1);
    chk("oflow_noreq", 64'(req_cycles), 64'd0);
    chk("oflow_sp", 64'(sp), 64'h800);
    run_op(1'b0, 1'b1, 2'b11);
    chk("limit_pop", 64'(last_pd), 64'h07FE);
    chk("limit_pop_sp", 64'(sp), 64'h801);

    // 6: reset during a waiting read
    ack_delay = 10;
    op_valid = 1'b1; op_push = 1'b0; op_pop = 1'b1; op_src = 2'b11;
    @(negedge clk);
    op_valid = 1'b0; op_pop = 1'b0;
    chk("rd_wait_req", 64'(mem_req), 64'd1);
    #2 reset = 1'b0;
    #1 chk("rst_req_drop", 64'(mem_req), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    ack_delay = 0;
    @(negedge clk);
    chk("rst2_sp", 64'(sp), 64'hFFF);
    chk("rst2_ready", 64'(op_ready), 64'd1);
    chk("rst2_req", 64'(mem_req), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
